mm_rd_seq: RTL and testbench
============================

# mm_rd_seq

Read-address sequencer for the A-operand path of the matrix-multiply datapath. On a start pulse it walks the A-bank address space `0 .. (M*M)/N-1` once per pass, for a programmable number of passes. It drives the single `rd_en`/`rd_addr` pair that the A-bank skew stage fans out to the N BRAM banks. After the last read it waits for the skew chain and BRAM read latency to flush, then reports completion.

## Interface
- `N`, default 3: systolic array dimension; the skew stage has N-1 register stages.
- `M`, default 6: matrix dimension. `DEPTH = (M*M)/N` words per bank, `AW = $clog2(DEPTH)`.
- `RD_LAT`, default 1: BRAM read latency in cycles.
- `DRAIN_CYC`, derived, `N-1+RD_LAT`: flush cycles after the last read.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a run. Sampled only while `busy=0`.
- `passes`, input, 8: number of passes. Latched on start acceptance.
- `stall`, input, 1: downstream backpressure. Suppresses issue for the current edge.
- `rd_en`, output, 1: registered read enable, feeds bank 0 of the skew stage.
- `rd_addr`, output, AW: registered read address.
- `pass_idx`, output, 8: index of the pass currently being issued.
- `busy`, output, 1: run in progress, including drain.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- Reset (asserted at any time, including mid-run):
  - state goes to IDLE immediately.
  - `rd_en`, `rd_addr`, `pass_idx`, `busy`, `done` all go to 0.
  - Internal counters clear.
  - No `done` is produced for an aborted run.
- States are IDLE, RUN, DRAIN.
- IDLE:
  - `start=1` at an edge latches `passes` and sets `busy=1`.
  - If `passes>0`: state goes to RUN, address counter 0, `pass_idx` 0.
  - If `passes=0`: `done=1` for the next cycle, `busy` stays 0, no reads, state stays IDLE.
  - `stall` is ignored.
- RUN, at each edge:
  - If `stall=0`: `rd_en<=1`, `rd_addr<=addr_cnt`, and the counter advances.
  - If `stall=1`: `rd_en<=0`, and `rd_addr`, `addr_cnt`, `pass_idx` hold.
  - When the issued address is DEPTH-1 and it is not the last pass: `addr_cnt` wraps to 0 and `pass_idx` increments. The next read continues with no bubble.
  - When the issued address is DEPTH-1 on pass `passes-1`: state goes to DRAIN and the drain counter loads `DRAIN_CYC`.
- DRAIN:
  - `rd_en=0`.
  - `rd_addr` holds its last value, DEPTH-1.
  - `stall` is ignored.
  - The counter decrements each edge. When it expires: `busy<=0`, `done<=1` for exactly one cycle, state goes to IDLE.
- `start` while `busy=1` is ignored and not queued.
- `start` in the cycle where `done=1` is accepted, since `busy=0` in that cycle.
- `pass_idx` holds its final value after the run, until the next accepted start or reset.
- Address arithmetic is unsigned AW bits. The compare against DEPTH-1 is explicit, so a non-power-of-two DEPTH wraps at DEPTH, not at 2^AW.

## Timing
- All outputs are registered. There is no combinational path from `start` or `stall` to any output.
- `start` accepted at edge e0:
  - `busy=1` after e0.
  - First read issues at edge e1 at the earliest, so `rd_en=1` and `rd_addr=0` are visible in the cycle after e1.
- Without stalls, reads occupy edges e1 .. eL, where `L = passes*DEPTH`. `rd_en` is high for exactly L consecutive cycles.
- Each stalled edge extends the run by exactly one cycle.
- Last read at edge eL:
  - `rd_en` falls at eL+1.
  - `done=1` and `busy=0` at edge eL+DRAIN_CYC+1.
  - `done` falls one edge later.
- Total reads per run = `passes*DEPTH`, independent of the stall pattern.

## Test plan
- Reset values: hold `rst_n=0`, then release → all outputs 0. Assert `rst_n=0` mid-RUN → all outputs 0 asynchronously, before the next clock edge. No `done` afterwards.
- Single pass, M=6, N=3, RD_LAT=1, `passes=1`, no stall:
  - Start at e0 → `rd_en` high for cycles after e1..e12 with `rd_addr` 0..11.
  - `done` pulses after e16 (DRAIN_CYC=3).
  - `busy` high e0..e15.
- Multi-pass, `passes=3`:
  - 36 reads, address sequence 0..11 repeated three times with no gap at the wraps.
  - `pass_idx` reads 0, 1, 2.
  - `done` after e40.
- Stall, `passes=1`, `stall=1` at edges e3, e4 and e12:
  - No `rd_en` on those edges, address held.
  - Address sequence is still exactly 0..11, with no skipped or duplicated address.
  - `done` after e19.
- Start handling:
  - `start` pulsed during RUN and during DRAIN → ignored, read count unchanged.
  - `start` held high through the `done` cycle → second run begins at that edge.
  - `passes=0` → `done` one cycle later, zero reads, `busy` never high.
- Non-power-of-two DEPTH, M=5, N=5 (DEPTH=5, AW=3), `passes=2` → addresses 0..4, 0..4; never 5, 6 or 7.

Source files
------------

// File: rtl/mm_rd_seq.sv
// mm_rd_seq: read-address sequencer for the A-operand bank path.
// Walks addresses 0..DEPTH-1 once per pass for a latched number of passes,
// then waits for the skew chain and BRAM read latency to flush before
// pulsing done.
module mm_rd_seq #(
  parameter  int N         = 3,
  parameter  int M         = 6,
  parameter  int RD_LAT    = 1,
  localparam int DEPTH     = (M * M) / N,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DRAIN_CYC = N - 1 + RD_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    passes,
  input  logic          stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [7:0]    pass_idx,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Drain counter must hold DRAIN_CYC; keep at least one bit.
  localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

  // Explicit wrap point so a non-power-of-two DEPTH never reaches 2^AW-1.
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] addr_cnt_reg, addr_cnt_next;
  logic [7:0]    passes_reg, passes_next;
  logic [DW-1:0] drain_cnt_reg, drain_cnt_next;

  logic          rd_en_next;
  logic [AW-1:0] rd_addr_next;
  logic [7:0]    pass_idx_next;
  logic          busy_next;
  logic          done_next;

  logic          last_addr_hit;
  logic          last_pass_hit;

  assign last_addr_hit = (addr_cnt_reg == LAST_ADDR);
  assign last_pass_hit = (pass_idx == (passes_reg - 8'd1));

  // Next-state and next-output logic for the IDLE/RUN/DRAIN sequencer.
  always_comb begin
    state_next     = state_reg;
    addr_cnt_next  = addr_cnt_reg;
    passes_next    = passes_reg;
    drain_cnt_next = drain_cnt_reg;
    rd_en_next     = 1'b0;
    rd_addr_next   = rd_addr;
    pass_idx_next  = pass_idx;
    busy_next      = busy;
    done_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          passes_next   = passes;
          pass_idx_next = 8'd0;
          addr_cnt_next = '0;
          if (passes != 8'd0) begin
            state_next = S_RUN;
            busy_next  = 1'b1;
          end else begin
            // Empty run: report completion without ever going busy.
            done_next = 1'b1;
          end
        end
      end

      S_RUN: begin
        // A stalled edge issues nothing and leaves address/pass untouched.
        if (!stall) begin
          rd_en_next   = 1'b1;
          rd_addr_next = addr_cnt_reg;
          if (last_addr_hit) begin
            addr_cnt_next = '0;
            if (last_pass_hit) begin
              state_next     = S_DRAIN;
              drain_cnt_next = DRAIN_LOAD;
            end else begin
              pass_idx_next = pass_idx + 8'd1;
            end
          end else begin
            addr_cnt_next = addr_cnt_reg + AW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_cnt_reg == '0) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg - DW'(1);
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run with no done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      addr_cnt_reg  <= '0;
      passes_reg    <= 8'd0;
      drain_cnt_reg <= '0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      pass_idx      <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_cnt_reg  <= addr_cnt_next;
      passes_reg    <= passes_next;
      drain_cnt_reg <= drain_cnt_next;
      rd_en         <= rd_en_next;
      rd_addr       <= rd_addr_next;
      pass_idx      <= pass_idx_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

endmodule

// File: tb/tb_mm_rd_seq.sv
// tb_mm_rd_seq: randomized bench for mm_rd_seq. The reference model counts
// issued reads against the stall pattern: read k carries address k%DEPTH,
// pass k/DEPTH, and done follows the last read by DRAIN_CYC+1 edges.
module tb_mm_rd_seq;

  localparam int N      = 3;
  localparam int M      = 6;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = (M * M) / N;
  localparam int AW     = $clog2(DEPTH);
  localparam int DRAIN  = N - 1 + RD_LAT;

  localparam int D5     = 5;
  localparam int AW5    = 3;
  localparam int DRAIN5 = 5 - 1 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start = 1'b0;
  logic [7:0]    passes = 8'd0;
  logic          stall = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    pass_idx;
  logic          busy;
  logic          done;

  logic           start5 = 1'b0;
  logic [7:0]     passes5 = 8'd0;
  logic           stall5 = 1'b0;
  logic           rd_en5;
  logic [AW5-1:0] rd_addr5;
  logic [7:0]     pass_idx5;
  logic           busy5;
  logic           done5;

  int n_checks = 0;
  int n_errors = 0;
  int model_addr = 0;

  always #5 clk = ~clk;

  mm_rd_seq #(.N(N), .M(M), .RD_LAT(RD_LAT)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .passes   (passes),
    .stall    (stall),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .pass_idx (pass_idx),
    .busy     (busy),
    .done     (done)
  );

  mm_rd_seq #(.N(5), .M(5), .RD_LAT(1)) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start5),
    .passes   (passes5),
    .stall    (stall5),
    .rd_en    (rd_en5),
    .rd_addr  (rd_addr5),
    .pass_idx (pass_idx5),
    .busy     (busy5),
    .done     (done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},    32'(rd_en),    32'd0);
    chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    chk({tag, "_pass_idx"}, 32'(pass_idx), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  // One run on the main DUT. Stall per edge comes from stall_mask (edges
  // below 32) or a random percentage. poke fires ignored starts mid-run;
  // chain_np >= 0 holds start through the done cycle to begin the next run.
  task automatic run(input int np, input int stall_pct, input logic [31:0] stall_mask,
                     input bit poke, input int chain_np, input bit pre_started,
                     output int done_edge, output int n_reads);
    int  total;
    int  issued;
    int  last_edge;
    int  e;
    int  exp_pidx;
    bit  st;
    bit  fin;
    bit  exp_busy;
    total     = np * DEPTH;
    issued    = 0;
    last_edge = -1;
    done_edge = -1;
    n_reads   = 0;
    if (!pre_started) begin
      @(negedge clk);
      start  = 1'b1;
      passes = 8'(np);
      stall  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("accept_busy",  32'(busy),  32'(np > 0));
      chk("accept_done",  32'(done),  32'(np == 0));
      chk("accept_rd_en", 32'(rd_en), 32'd0);
      if (np > 0) chk("accept_pass_idx", 32'(pass_idx), 32'd0);
    end
    if (np == 0) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("zero_done_fall", 32'(done),  32'd0);
      chk("zero_busy",      32'(busy),  32'd0);
      chk("zero_rd_en",     32'(rd_en), 32'd0);
      $display("run passes=0 reads=0 done after one cycle");
      return;
    end
    e = 0;
    forever begin
      e++;
      if (e > 3000) begin
        chk("run_timeout", 32'd1, 32'd0);
        break;
      end
      fin = (last_edge >= 0) && (e == last_edge + DRAIN + 2);
      @(negedge clk);
      st     = ((e < 32) && stall_mask[e]) || (32'($urandom_range(0, 99)) < 32'(stall_pct));
      stall  = st;
      passes = 8'($urandom);
      if (fin) begin
        start  = (chain_np >= 0);
        passes = 8'(chain_np);
      end else if ((chain_np >= 0) && (last_edge >= 0) && (e == last_edge + DRAIN + 1)) begin
        start = 1'b1;
      end else begin
        start = poke && ($urandom_range(0, 3) == 0);
      end
      @(posedge clk);
      #1;
      if (issued < total) begin
        if (!st) begin
          model_addr = issued % DEPTH;
          issued++;
          if (issued == total) last_edge = e;
          chk("rd_en_issue", 32'(rd_en), 32'd1);
        end else begin
          chk("rd_en_stall", 32'(rd_en), 32'd0);
        end
      end else begin
        chk("rd_en_drain", 32'(rd_en), 32'd0);
      end
      chk("rd_addr", 32'(rd_addr), 32'(model_addr));
      exp_pidx = (issued < total) ? issued / DEPTH : np - 1;
      if (fin && chain_np >= 0) exp_pidx = 0;
      chk("pass_idx", 32'(pass_idx), 32'(exp_pidx));
      exp_busy = !((last_edge >= 0) && (e >= last_edge + DRAIN + 1));
      if (fin && chain_np > 0) exp_busy = 1'b1;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'((last_edge >= 0) && (e == last_edge + DRAIN + 1)));
      if (done && done_edge < 0) done_edge = e;
      if (rd_en) n_reads++;
      if (fin) break;
    end
    $display("run passes=%0d stall_pct=%0d reads=%0d done_edge=%0d", np, stall_pct, n_reads, done_edge);
  endtask

  int de;
  int nr;
  int k5;
  int last5;
  int np_r;
  logic [31:0] mask;

  initial begin
    // Reset held, then released.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset_released");
    model_addr = 0;

    // Single pass, no stall.
    run(1, 0, 32'd0, 1'b0, -1, 1'b0, de, nr);
    chk("single_done_edge", 32'(de), 32'd16);
    chk("single_reads", 32'(nr), 32'd12);

    // Three passes, no stall.
    run(3, 0, 32'd0, 1'b0, -1, 1'b0, de, nr);
    chk("multi_done_edge", 32'(de), 32'd40);
    chk("multi_reads", 32'(nr), 32'd36);

    // Stalls on edges 3, 4 and 12.
    mask = (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 12);
    run(1, 0, mask, 1'b0, -1, 1'b0, de, nr);
    chk("stall_done_edge", 32'(de), 32'd19);
    chk("stall_reads", 32'(nr), 32'd12);

    // Starts poked during RUN and DRAIN are ignored.
    run(2, 25, 32'd0, 1'b1, -1, 1'b0, de, nr);
    chk("poke_reads", 32'(nr), 32'd24);

    // Zero passes.
    run(0, 0, 32'd0, 1'b0, -1, 1'b0, de, nr);

    // Start held through done launches the next run on that edge.
    run(1, 20, 32'd0, 1'b1, 2, 1'b0, de, nr);
    chk("chain_first_reads", 32'(nr), 32'd12);
    run(2, 20, 32'd0, 1'b1, -1, 1'b1, de, nr);
    chk("chain_second_reads", 32'(nr), 32'd24);

    // Random passes and stall densities.
    for (int i = 0; i < 4; i++) begin
      np_r = $urandom_range(1, 4);
      run(np_r, $urandom_range(0, 40), 32'd0, 1'b1, -1, 1'b0, de, nr);
      chk("rand_reads", 32'(nr), 32'(np_r * DEPTH));
    end

    // Reset mid-run: outputs clear before the next edge, no done afterwards.
    @(negedge clk);
    start  = 1'b1;
    passes = 8'd2;
    stall  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    model_addr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_busy", 32'(busy), 32'd0);
    end
    $display("run aborted by reset, no done observed afterwards");

    // Non-power-of-two depth: addresses 0..4 twice, never 5..7.
    @(negedge clk);
    start5  = 1'b1;
    passes5 = 8'd2;
    @(posedge clk);
    #1;
    chk("d5_accept_busy", 32'(busy5), 32'd1);
    k5    = 0;
    last5 = -1;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      start5 = 1'b0;
      stall5 = ($urandom_range(0, 99) < 30);
      @(posedge clk);
      #1;
      if (rd_en5) begin
        chk("d5_addr", 32'(rd_addr5), 32'(k5 % D5));
        k5++;
        if (k5 == 2 * D5) last5 = e;
      end
      if (done5) begin
        chk("d5_reads", 32'(k5), 32'(2 * D5));
        chk("d5_done_gap", 32'(e - last5), 32'(DRAIN5 + 1));
        break;
      end
      if (e == 300) chk("d5_timeout", 32'd1, 32'd0);
    end
    $display("run depth5 passes=2 reads=%0d", k5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
